// File: rtl/datapath_pkg.sv
// ============================================================================
// datapath_pkg : shared types and operand/write-port indices for the
//                pipelined datapath and its register file.
// Revision     : 1.0  initial release
// ============================================================================
`default_nettype none

package datapath_pkg;

  localparam int DP_WIDTH = 32;
  localparam int DP_NREGS = 16;
  localparam int DP_AW    = $clog2(DP_NREGS);

  typedef logic [DP_AW-1:0]    reg_addr_t;
  typedef logic [DP_WIDTH-1:0] word_t;

  localparam int OPND_A = 0;
  localparam int OPND_B = 1;
  localparam int OPND_C = 2;
  localparam int OPND_D = 3;

  localparam int WR_Y1 = 0;
  localparam int WR_Y2 = 1;

endpackage

`default_nettype wire

// File: rtl/regfile_2w4r.sv
// ============================================================================
// regfile_2w4r : NREGS x WIDTH register file, 4 async reads, 1 registered
//                debug read, 2 write ports (Y2 wins on same address).
//                Option macro: DATAPATH_ZERO_R0_EN (r0 hardwired to zero).
// Revision     : 1.0  initial release
// ============================================================================
`default_nettype none

module regfile_2w4r
  import datapath_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NREGS = 16,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [AW-1:0]    i_raddr [4],
  output logic [WIDTH-1:0] o_rdata [4],
  input  logic [1:0]       i_we,
  input  logic [AW-1:0]    i_waddr [2],
  input  logic [WIDTH-1:0] i_wdata [2],
  input  logic [AW-1:0]    i_dbg_addr,
  output logic [WIDTH-1:0] o_dbg_data
);

`ifdef DATAPATH_ZERO_R0_EN
  localparam int FIRST_RW = 1;
`else
  localparam int FIRST_RW = 0;
`endif

  logic [WIDTH-1:0] r_regs [NREGS];
  logic [WIDTH-1:0] r_dbg_data;

  // Only rows FIRST_RW..NREGS-1 are addressable, so r0 reads zero when hardwired.
  function automatic logic [WIDTH-1:0] f_read(input logic [AW-1:0] a);
    f_read = '0;
    for (int r = FIRST_RW; r < NREGS; r++) begin
      if (a == AW'(r)) f_read = r_regs[r];
    end
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREGS; r++) r_regs[r] <= '0;
      r_dbg_data <= '0;
    end else begin
      r_dbg_data <= f_read(i_dbg_addr);
      for (int r = FIRST_RW; r < NREGS; r++) begin
        if (i_we[WR_Y1] && i_waddr[WR_Y1] == AW'(r)) r_regs[r] <= i_wdata[WR_Y1];
        if (i_we[WR_Y2] && i_waddr[WR_Y2] == AW'(r)) r_regs[r] <= i_wdata[WR_Y2];
      end
    end
  end

  always_comb begin
    for (int p = 0; p < 4; p++) o_rdata[p] = f_read(i_raddr[p]);
  end

  assign o_dbg_data = r_dbg_data;

endmodule

`default_nettype wire

// File: rtl/pipelined_datapath.sv
// ============================================================================
// pipelined_datapath : issue stage (operand select + WB bypass) feeding an
//                      external ALU, WB register committing one cycle later.
//                      Option macro: DATAPATH_ZERO_R0_EN (r0 hardwired to zero).
// Revision           : 1.0  initial release
// ============================================================================
`default_nettype none

module pipelined_datapath
  import datapath_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NREGS = 16,
  parameter int AW    = $clog2(NREGS),
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             hold,
  input  logic [AW-1:0]    a_addr,
  input  logic [AW-1:0]    b_addr,
  input  logic [AW-1:0]    c_addr,
  input  logic [AW-1:0]    d_addr,
  input  logic [AW-1:0]    y1_addr,
  input  logic [AW-1:0]    y2_addr,
  input  logic [3:0]       zero_reg,
  input  logic [1:0]       write,
  input  logic             const_a,
  input  logic [WIDTH-1:0] constant,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [WIDTH-1:0] alu_c,
  output logic [WIDTH-1:0] alu_d,
  input  logic [WIDTH-1:0] alu_y1,
  input  logic [WIDTH-1:0] alu_y2,
  output logic             wb_valid,
  output logic [CNT_W-1:0] retire_count,
  input  logic [AW-1:0]    dbg_addr,
  output logic [WIDTH-1:0] dbg_data
);

`ifdef DATAPATH_ZERO_R0_EN
  localparam logic ZERO_R0 = 1'b1;
`else
  localparam logic ZERO_R0 = 1'b0;
`endif

  logic             r_wb_valid;
  logic [WIDTH-1:0] r_wb_d1;
  logic [WIDTH-1:0] r_wb_d2;
  logic [AW-1:0]    r_wb_y1;
  logic [AW-1:0]    r_wb_y2;
  logic [1:0]       r_wb_write;
  logic [CNT_W-1:0] r_retire;

  logic             w_accept;
  logic [AW-1:0]    w_raddr [4];
  logic [WIDTH-1:0] w_rdata [4];
  logic [WIDTH-1:0] w_opnd  [4];
  logic [AW-1:0]    w_waddr [2];
  logic [WIDTH-1:0] w_wdata [2];
  logic [1:0]       w_we;

  assign in_ready = ~hold;
  assign w_accept = in_valid & ~hold;

  assign w_raddr[OPND_A] = a_addr;
  assign w_raddr[OPND_B] = b_addr;
  assign w_raddr[OPND_C] = c_addr;
  assign w_raddr[OPND_D] = d_addr;

  assign w_waddr[WR_Y1] = r_wb_y1;
  assign w_waddr[WR_Y2] = r_wb_y2;
  assign w_wdata[WR_Y1] = r_wb_d1;
  assign w_wdata[WR_Y2] = r_wb_d2;
  assign w_we           = {2{r_wb_valid}} & r_wb_write;

  regfile_2w4r #(
    .WIDTH (WIDTH),
    .NREGS (NREGS),
    .AW    (AW)
  ) u_regfile (
    .clk        (clk),
    .rst        (rst),
    .i_raddr    (w_raddr),
    .o_rdata    (w_rdata),
    .i_we       (w_we),
    .i_waddr    (w_waddr),
    .i_wdata    (w_wdata),
    .i_dbg_addr (dbg_addr),
    .o_dbg_data (dbg_data)
  );

  // Later assignments take priority: Y1 bypass < Y2 bypass < constant < zero.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      w_opnd[i] = w_rdata[i];
      if (!ZERO_R0 || w_raddr[i] != '0) begin
        if (r_wb_valid && r_wb_write[WR_Y1] && r_wb_y1 == w_raddr[i]) w_opnd[i] = r_wb_d1;
        if (r_wb_valid && r_wb_write[WR_Y2] && r_wb_y2 == w_raddr[i]) w_opnd[i] = r_wb_d2;
      end
      if (i == OPND_A && const_a) w_opnd[i] = constant;
      if (zero_reg[i]) w_opnd[i] = '0;
    end
  end

  assign alu_a = w_opnd[OPND_A];
  assign alu_b = w_opnd[OPND_B];
  assign alu_c = w_opnd[OPND_C];
  assign alu_d = w_opnd[OPND_D];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wb_valid <= 1'b0;
      r_wb_d1    <= '0;
      r_wb_d2    <= '0;
      r_wb_y1    <= '0;
      r_wb_y2    <= '0;
      r_wb_write <= '0;
      r_retire   <= '0;
    end else begin
      r_wb_valid <= w_accept;
      if (w_accept) begin
        r_wb_d1    <= alu_y1;
        r_wb_d2    <= alu_y2;
        r_wb_y1    <= y1_addr;
        r_wb_y2    <= y2_addr;
        r_wb_write <= write;
      end
      if (r_wb_valid) r_retire <= r_retire + CNT_W'(1);
    end
  end

  assign wb_valid     = r_wb_valid;
  assign retire_count = r_retire;

endmodule

`default_nettype wire
